// File: rtl/imem_loader.sv
// Loads a length-prefixed, MSB-first word stream into instruction memory, then releases the core reset.
// One write cycle per word after its 4th byte; byte_ready_87_o is high only in HDR_HI/HDR_LO/DATA (stream stalls otherwise).
module imem_loader #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    DEPTH_LOG2 = 8
) (
    input  logic                  clk_87,
    input  logic                  rst_87,
    input  logic                  start_87,
    input  logic                  byte_valid_87,
    input  logic [7:0]            byte_data_87,
    output logic                  byte_ready_87,
    output logic                  imem_we_87,
    output logic [ADDR_WIDTH-1:0] imem_addr_87,
    output logic [31:0]           imem_wdata_87,
    output logic                  cpu_rst_87,
    output logic                  load_done_87,
    output logic                  load_err_87
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam int          IDX_W   = DEPTH_LOG2 + 1;
    localparam logic [16:0] MAX_LEN = 17'd1 << DEPTH_LOG2;

    state_t                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [23:0]             word_q, word_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;

    logic                    ready;
    logic                    xfer;
    logic [15:0]             len_full;

    assign ready    = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
    assign xfer     = ready && byte_valid_87;
    assign len_full = {len_q[15:8], byte_data_87};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (start_87) state_d = HDR_HI;
            end
            HDR_HI: begin
                if (xfer) begin
                    len_d[15:8] = byte_data_87;
                    state_d     = HDR_LO;
                end
            end
            HDR_LO: begin
                if (xfer) begin
                    len_d = len_full;
                    if ((len_full == 16'd0) || ({1'b0, len_full} > MAX_LEN)) begin
                        state_d = ERR;
                    end else begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    cnt_d  = cnt_q + 2'd1;
                    word_d = {word_q[15:0], byte_data_87};
                    if (cnt_q == 2'd3) begin
                        // Address and data are captured here so they hold after the strobe drops.
                        wdata_d = {word_q, byte_data_87};
                        addr_d  = BASE_ADDR + (ADDR_WIDTH'(idx_q) << 2);
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                idx_d = idx_q + 1'b1;
                if ((32'(idx_q) + 32'd1) == 32'(len_q)) state_d = DONE;
                else                                      state_d = DATA;
            end
            DONE, ERR: begin
                if (start_87) begin
                    len_d   = '0;
                    state_d = HDR_HI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_87 or posedge rst_87) begin
        if (rst_87) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign byte_ready_87 = ready;
    assign imem_we_87    = (state_q == WRITE);
    assign imem_addr_87  = addr_q;
    assign imem_wdata_87 = wdata_q;
    assign cpu_rst_87    = (state_q != DONE);
    assign load_done_87  = (state_q == DONE);
    assign load_err_87   = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected writes come from the stream contents (word i -> BASE + 4*i).
module tb_imem_loader;
    localparam int          AW   = 32;
    localparam int          DL   = 8;
    localparam logic [31:0] BASE = 32'h0;

    logic          clk = 1'b0;
    logic          rst, start, bvld;
    logic [7:0]    bdat;
    logic          bready, we, cpu_rst, done, err;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .DEPTH_LOG2(DL)) dut (
        .clk_87(clk), .rst_87(rst), .start_87(start),
        .byte_valid_87(bvld), .byte_data_87(bdat), .byte_ready_87(bready),
        .imem_we_87(we), .imem_addr_87(addr), .imem_wdata_87(wdata),
        .cpu_rst_87(cpu_rst), .load_done_87(done), .load_err_87(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [31:0] words[$];

    always @(negedge clk) begin
        if (we) begin
            obs_addr.push_back(addr);
            obs_data.push_back(wdata);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: a valid load of n words writes words[i] at BASE + 4*i, in order, once each.
    function automatic int model_mismatches(input int n);
        int m = 0;
        if (obs_addr.size() != n) m++;
        for (int i = 0; i < n && i < obs_addr.size(); i++) begin
            if (obs_addr[i] !== BASE + 32'(4 * i)) m++;
            if (obs_data[i] !== words[i]) m++;
        end
        return m;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
        logic r;
        int   n;
        repeat (gap) begin
            bvld = 1'b0;
            bdat = 8'($urandom);
            if (noise) start = 1'($urandom);
            tick;
        end
        bvld = 1'b1;
        bdat = b;
        if (noise) start = 1'($urandom);
        n = 0;
        forever begin
            @(negedge clk);
            r = bready;
            tick;
            if (r) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL send_byte timeout: byte_ready stayed 0 for %0d cycles, required 1", n);
                break;
            end
        end
        if (noise) start = 1'b0;
    endtask

    // mode 0: random gaps 0..gmax; mode 1: alternate idle cycles, but first byte of each later word follows the previous word with no gap (valid held through WRITE).
    task automatic drive_load(input logic [15:0] len, input bit do_start, input int mode, input int gmax, input bit noise);
        if (do_start) begin
            start = 1'b1;
            tick;
            start = 1'b0;
        end
        send_byte(len[15:8], (mode == 1) ? 1 : $urandom_range(gmax, 0), noise);
        send_byte(len[7:0], (mode == 1) ? 1 : $urandom_range(gmax, 0), noise);
        for (int w = 0; w < words.size(); w++) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] wv;
                int          g;
                wv = words[w];
                if (mode == 1) g = (k == 0 && w > 0) ? 0 : 1;
                else           g = $urandom_range(gmax, 0);
                send_byte(wv[31 - 8*k -: 8], g, noise);
            end
        end
        bvld  = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done;
        int cyc = 0;
        while (!done && !err && cyc < 40) begin
            tick;
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; bvld = 1'b0; bdat = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (bready !== 1'b1) begin errors++; $display("FAIL reset_pre_ready: got %b, required 1", bready); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", bready); end
        checks++;
        if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b, required 1", cpu_rst); end
        checks++;
        if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, required 0", we); end
        checks++;
        if (addr !== BASE) begin errors++; $display("FAIL reset_addr: got %h, required %h", addr, BASE); end
        checks++;
        if (wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h, required 0", wdata); end
        checks++;
        if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: got done=%b err=%b, required 0 0", done, err); end
        @(posedge clk);
        #1 rst = 1'b0;
        tick;
    endtask

    task automatic test_normal;
        obs_addr.delete(); obs_data.delete();
        words = '{32'hDEADBEEF, 32'h00000001};
        drive_load(16'd2, 1'b1, 0, 0, 1'b0);
        @(negedge clk);
        checks++;
        if (we !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL normal_lat_we: got we=%b done=%b, required 1 0", we, done); end
        @(negedge clk);
        checks++;
        if (we !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL normal_lat_done: got we=%b done=%b, required 0 1", we, done); end
        checks++;
        if (model_mismatches(2) !== 0) begin errors++; $display("FAIL normal_writes: got %0d mismatches (%0d writes), required 0 (2 writes)", model_mismatches(2), obs_addr.size()); end
        checks++;
        if (cpu_rst !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL normal_flags: got cpu_rst=%b err=%b, required 0 0", cpu_rst, err); end
        checks++;
        if (addr !== 32'h4 || wdata !== 32'h1) begin errors++; $display("FAIL normal_hold: got addr=%h wdata=%h, required 4 00000001", addr, wdata); end
    endtask

    task automatic test_backpressure;
        obs_addr.delete(); obs_data.delete();
        words = '{32'hDEADBEEF, 32'h00000001};
        drive_load(16'd2, 1'b1, 1, 0, 1'b0);
        wait_done;
        checks++;
        if (model_mismatches(2) !== 0) begin errors++; $display("FAIL bp_writes: got %0d mismatches (%0d writes), required 0 (2 writes)", model_mismatches(2), obs_addr.size()); end
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0) begin errors++; $display("FAIL bp_done: got done=%b cpu_rst=%b, required 1 0", done, cpu_rst); end
    endtask

    task automatic test_zero_len;
        obs_addr.delete(); obs_data.delete();
        words.delete();
        drive_load(16'd0, 1'b1, 0, 0, 1'b0);
        bvld = 1'b1; bdat = 8'hAA;
        repeat (3) tick;
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero_err: got err=%b done=%b, required 1 0", err, done); end
        checks++;
        if (bready !== 1'b0 || cpu_rst !== 1'b1) begin errors++; $display("FAIL zero_ready: got ready=%b cpu_rst=%b, required 0 1", bready, cpu_rst); end
        checks++;
        if (obs_addr.size() !== 0) begin errors++; $display("FAIL zero_nowrite: got %0d writes, required 0", obs_addr.size()); end
        bvld = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        tick;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || cpu_rst !== 1'b1 || bready !== 1'b1) begin errors++; $display("FAIL zero_restart: got err=%b cpu_rst=%b ready=%b, required 0 1 1", err, cpu_rst, bready); end
        words = '{32'hDEADBEEF, 32'h00000001};
        #2;
        drive_load(16'd2, 1'b0, 0, 2, 1'b0);
        wait_done;
        checks++;
        if (model_mismatches(2) !== 0 || done !== 1'b1) begin errors++; $display("FAIL zero_reload: got %0d mismatches done=%b, required 0 1", model_mismatches(2), done); end
    endtask

    task automatic test_oversize;
        obs_addr.delete(); obs_data.delete();
        words.delete();
        drive_load(16'h0101, 1'b1, 0, 1, 1'b0);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || bready !== 1'b0 || cpu_rst !== 1'b1) begin errors++; $display("FAIL over_err: got err=%b ready=%b cpu_rst=%b, required 1 0 1", err, bready, cpu_rst); end
        for (int i = 0; i < 256; i++) words.push_back($urandom);
        #2;
        drive_load(16'h0100, 1'b1, 0, 0, 1'b0);
        wait_done;
        checks++;
        if (model_mismatches(256) !== 0) begin errors++; $display("FAIL max_writes: got %0d mismatches (%0d writes), required 0 (256 writes)", model_mismatches(256), obs_addr.size()); end
        checks++;
        if (obs_addr.size() == 256 && obs_addr[255] !== 32'h3FC) begin errors++; $display("FAIL max_last_addr: got %h, required 3fc", obs_addr[255]); end
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL max_done: got done=%b err=%b, required 1 0", done, err); end
    endtask

    task automatic test_midload_reset;
        obs_addr.delete(); obs_data.delete();
        start = 1'b1;
        tick;
        start = 1'b0;
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'hDE, 0, 1'b0);
        send_byte(8'hAD, 0, 1'b0);
        send_byte(8'hBE, 0, 1'b0);
        bvld = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (addr !== BASE || wdata !== 32'h0 || done !== 1'b0 || cpu_rst !== 1'b1) begin errors++; $display("FAIL midrst_outputs: got addr=%h wdata=%h done=%b cpu_rst=%b, required 0 0 0 1", addr, wdata, done, cpu_rst); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick;
        checks++;
        if (obs_addr.size() !== 0 || we !== 1'b0) begin errors++; $display("FAIL midrst_nowrite: got %0d writes we=%b, required 0 0", obs_addr.size(), we); end
        words = '{32'hDEADBEEF, 32'h00000001};
        drive_load(16'd2, 1'b1, 0, 1, 1'b0);
        wait_done;
        checks++;
        if (model_mismatches(2) !== 0 || done !== 1'b1) begin errors++; $display("FAIL midrst_reload: got %0d mismatches done=%b, required 0 1", model_mismatches(2), done); end
    endtask

    // Back-to-back random loads restarted from DONE, with start toggled randomly mid-load.
    task automatic test_back_to_back;
        for (int it = 0; it < 5; it++) begin
            int n;
            n = $urandom_range(8, 1);
            obs_addr.delete(); obs_data.delete();
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            drive_load(16'(n), 1'b1, 0, 2, 1'b1);
            wait_done;
            checks++;
            if (model_mismatches(n) !== 0) begin errors++; $display("FAIL rand_writes[%0d]: got %0d mismatches (%0d writes), required 0 (%0d writes)", it, model_mismatches(n), obs_addr.size(), n); end
            checks++;
            if (done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b0) begin errors++; $display("FAIL rand_flags[%0d]: got done=%b err=%b cpu_rst=%b, required 1 0 0", it, done, err, cpu_rst); end
            #2;
        end
    endtask

    initial begin
        test_reset;
        test_normal;
        test_backpressure;
        test_zero_len;
        test_oversize;
        test_midload_reset;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
